lcd_write_sched: RTL and testbench

Owns the character-LCD bus (rs/rw/en/data) and sequences every write to it. After reset it runs the HD44780 power-up wait and a fixed 4-command init. It then arbitrates round-robin between two requesters (calculator expression writer, status/result writer) using a valid/ready handshake. It generates each enable pulse and the post-command wait from a shared tick divider.

---
 rtl/lcd_write_sched.sv | 173 +++++++++++++++++
 tb/tb_lcd_write_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_sched.sv
// Character-LCD write scheduler: power-up wait, fixed init command list, then
// round-robin arbitration of two requesters onto the HD44780 bus.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PWR_WAIT  | counting power-up ticks after reset
// INIT_LOAD | driving the next init ROM byte onto the bus
// SETUP     | rs/data stable, waiting for the next tick to raise en
// EN_HIGH   | en asserted for EN_TICKS ticks
// HOLD_WAIT | en low, waiting out the command execution time
// IDLE      | init complete, arbitrating requesters every clk
module lcd_write_sched #(
  parameter int TICK_DIV       = 250,
  parameter int EN_TICKS       = 1,
  parameter int CMD_WAIT_TICKS = 10,
  parameter int CLR_WAIT_TICKS = 400,
  parameter int PWR_TICKS      = 3000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int CNT_W   = $clog2(TICK_DIV);
  localparam int MAX_A   = (PWR_TICKS > CLR_WAIT_TICKS) ? PWR_TICKS : CLR_WAIT_TICKS;
  localparam int MAX_B   = (CMD_WAIT_TICKS > EN_TICKS) ? CMD_WAIT_TICKS : EN_TICKS;
  localparam int TMR_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_LOAD,
    SETUP,
    EN_HIGH,
    HOLD_WAIT,
    IDLE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   tick_cnt;
  logic               tick;
  logic [TMR_W-1:0]   tmr;
  logic [1:0]         init_idx;
  logic               last_grant;
  logic               grant0;
  logic               grant1;
  logic               long_wait;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Free-running timebase; the FSM only samples it, never restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  // Clear and home need the long execution wait; everything else is short.
  assign long_wait = !lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02 || lcd_data == 8'h03);

  assign grant0 = (state == IDLE) && init_done && req0_valid && (!req1_valid || last_grant);
  assign grant1 = (state == IDLE) && init_done && req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);
  assign lcd_rw     = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PWR_WAIT;
      tmr        <= TMR_W'(PWR_TICKS - 1);
      init_idx   <= 2'd0;
      init_done  <= 1'b0;
      last_grant <= 1'b1;
      lcd_rs     <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_data   <= 8'h00;
    end else begin
      case (state)
        PWR_WAIT: begin
          if (tick) begin
            if (tmr == '0) begin
              init_idx <= 2'd0;
              state    <= INIT_LOAD;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
        end
        INIT_LOAD: begin
          lcd_rs   <= 1'b0;
          lcd_data <= init_byte(init_idx);
          state    <= SETUP;
        end
        SETUP: begin
          if (tick) begin
            lcd_en <= 1'b1;
            tmr    <= TMR_W'(EN_TICKS - 1);
            state  <= EN_HIGH;
          end
        end
        EN_HIGH: begin
          if (tick) begin
            if (tmr == '0) begin
              lcd_en <= 1'b0;
              tmr    <= long_wait ? TMR_W'(CLR_WAIT_TICKS - 1) : TMR_W'(CMD_WAIT_TICKS - 1);
              state  <= HOLD_WAIT;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
        end
        HOLD_WAIT: begin
          if (tick) begin
            if (tmr != '0) begin
              tmr <= tmr - TMR_W'(1);
            end else if (init_done) begin
              state <= IDLE;
            end else if (init_idx == 2'd3) begin
              init_done <= 1'b1;
              state     <= IDLE;
            end else begin
              init_idx <= init_idx + 2'd1;
              state    <= INIT_LOAD;
            end
          end
        end
        IDLE: begin
          if (grant0) begin
            lcd_rs     <= req0_rs;
            lcd_data   <= req0_data;
            last_grant <= 1'b0;
            state      <= SETUP;
          end else if (grant1) begin
            lcd_rs     <= req1_rs;
            lcd_data   <= req1_data;
            last_grant <= 1'b1;
            state      <= SETUP;
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_sched.sv
// Scoreboard bench for lcd_write_sched: requesters push expected bus writes,
// a negedge monitor checks arbitration, pulse shape and post-write waits.
module tb_lcd_write_sched;

  localparam int TD   = 4;
  localparam int PWR  = 5;
  localparam int ENT  = 1;
  localparam int CMDW = 2;
  localparam int CLRW = 6;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         gap;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       v[2];
  logic       rsv[2];
  logic [7:0] dv[2];
  logic       rdy[2];
  logic       init_done, busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;
  logic       req0_ready, req1_ready;

  int checks = 0;
  int errors = 0;

  wr_t exp_q[$];
  int  grants[$];
  wr_t cur;
  int  m_last;
  logic prev_en;
  int  en_cnt, gap_cnt, gap_exp, clk_since;
  bit  gap_active, first_en;

  always #5 clk = ~clk;

  assign rdy[0] = req0_ready;
  assign rdy[1] = req1_ready;

  lcd_write_sched #(
    .TICK_DIV(TD), .EN_TICKS(ENT), .CMD_WAIT_TICKS(CMDW),
    .CLR_WAIT_TICKS(CLRW), .PWR_TICKS(PWR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0]), .req0_rs(rsv[0]), .req0_data(dv[0]), .req0_ready(req0_ready),
    .req1_valid(v[1]), .req1_rs(rsv[1]), .req1_data(dv[1]), .req1_ready(req1_ready),
    .init_done(init_done), .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .lcd_data(lcd_data)
  );

  task automatic chk(input string name, input bit pass, input int act, input int expv);
    checks++;
    if (!pass) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
    end
  endtask

  // Wait time after en falls, straight from the command classification rules.
  function automatic int wait_ticks(input logic r, input logic [7:0] d);
    return (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? CLRW : CMDW;
  endfunction

  function automatic wr_t mk(input logic r, input logic [7:0] d, input int gap);
    wr_t w;
    w.rs = r; w.d = d; w.gap = gap;
    return w;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      grants.delete();
      // Init writes followed by another init write: wait plus one tick for the next SETUP.
      exp_q.push_back(mk(1'b0, 8'h38, (CMDW + 1) * TD));
      exp_q.push_back(mk(1'b0, 8'h0C, (CMDW + 1) * TD));
      exp_q.push_back(mk(1'b0, 8'h06, (CMDW + 1) * TD));
      exp_q.push_back(mk(1'b0, 8'h01, CLRW * TD));
      m_last = 1; prev_en = 1'b0; en_cnt = 0; gap_cnt = 0;
      gap_active = 0; first_en = 1; clk_since = 0;
    end else begin
      clk_since++;
      if (req0_ready || req1_ready) begin
        int g, eg;
        g  = req1_ready ? 1 : 0;
        eg = (v[0] && v[1]) ? 1 - m_last : (v[0] ? 0 : 1);
        chk("ready_onehot", !(req0_ready && req1_ready), req0_ready + req1_ready, 1);
        chk("ready_in_idle", !busy && init_done, {busy, init_done}, 1);
        chk("grant_order", g == eg, g, eg);
        chk("ready_with_valid", v[g], v[g], 1);
        m_last = g;
        grants.push_back(g);
        exp_q.push_back(mk(rsv[g], dv[g], wait_ticks(rsv[g], dv[g]) * TD));
      end else if (!busy && init_done && (v[0] || v[1])) begin
        chk("idle_grant_missing", 1'b0, {v[1], v[0]}, 0);
      end
      if (!busy) chk("idle_after_init", init_done, init_done, 1);

      if (gap_active) begin
        gap_cnt++;
        if (!busy || (lcd_en && !prev_en)) begin
          chk("post_en_wait", gap_cnt == gap_exp, gap_cnt, gap_exp);
          gap_active = 0;
        end
      end

      if (lcd_en && !prev_en) begin
        if (first_en) begin
          chk("powerup_delay", clk_since >= PWR * TD + 1 && clk_since <= PWR * TD + 1 + TD,
              clk_since, PWR * TD + 1);
          first_en = 0;
        end
        chk("lcd_rw_low", lcd_rw == 1'b0, lcd_rw, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1'b0, lcd_data, 0);
          cur = mk(lcd_rs, lcd_data, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("write_rs", lcd_rs == cur.rs, lcd_rs, cur.rs);
          chk("write_data", lcd_data == cur.d, lcd_data, cur.d);
        end
        en_cnt = 1;
      end else if (lcd_en) begin
        en_cnt++;
      end else if (prev_en) begin
        chk("en_width", en_cnt == ENT * TD, en_cnt, ENT * TD);
        chk("hold_rs", lcd_rs == cur.rs, lcd_rs, cur.rs);
        chk("hold_data", lcd_data == cur.d, lcd_data, cur.d);
        gap_active = 1; gap_cnt = 0; gap_exp = cur.gap;
      end
      prev_en = lcd_en;
    end
  end

  task automatic send(input int id, input logic r, input logic [7:0] d);
    int t;
    t = 0;
    v[id] = 1'b1; rsv[id] = r; dv[id] = d;
    forever begin
      @(negedge clk);
      if (rdy[id]) break;
      t++;
      if (t > 5000) begin
        chk("handshake_timeout", 1'b0, id, -1);
        break;
      end
    end
    @(posedge clk); #1;
    v[id] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(init_done && !busy && !gap_active && exp_q.size() == 0) && t < 20000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20000) chk("idle_timeout", 1'b0, exp_q.size(), 0);
  endtask

  task automatic rand_traffic(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      logic       r;
      logic [7:0] d;
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) begin
        r = 1'b0; d = 8'($urandom_range(1, 3));
      end else begin
        r = 1'($urandom_range(0, 1)); d = 8'($urandom_range(0, 255));
      end
      send(id, r, d);
    end
  endtask

  initial begin
    int t;
    v[0] = 0; v[1] = 0; rsv[0] = 0; rsv[1] = 0; dv[0] = 0; dv[1] = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_lcd_en", lcd_en == 0, lcd_en, 0);
    chk("rst_lcd_data", lcd_data == 8'h00, lcd_data, 0);
    chk("rst_lcd_rs", lcd_rs == 0, lcd_rs, 0);
    chk("rst_init_done", init_done == 0, init_done, 0);
    chk("rst_busy", busy == 1, busy, 1);
    chk("rst_ready", !req0_ready && !req1_ready, {req1_ready, req0_ready}, 0);

    // Request pending from power-up: must be held off until init completes.
    fork
      send(0, 1'b1, 8'h35);
      begin
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
      end
    join
    wait_idle();

    send(1, 1'b0, 8'h01);
    send(0, 1'b0, 8'h80);
    wait_idle();

    fork
      rand_traffic(0, 20);
      rand_traffic(1, 20);
    join
    wait_idle();

    // Reset while en is high mid-write.
    send(0, 1'b1, 8'h41);
    t = 0;
    while (!lcd_en && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("en_seen_before_reset", lcd_en, lcd_en, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_lcd_en", lcd_en == 0, lcd_en, 0);
    chk("midrst_lcd_data", lcd_data == 8'h00, lcd_data, 0);
    chk("midrst_init_done", init_done == 0, init_done, 0);
    chk("midrst_busy", busy == 1, busy, 1);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;

    // Continuous contention from reset: alternate starting with requester 0.
    fork
      begin send(0, 1'b1, 8'h31); send(0, 1'b1, 8'h31); end
      begin send(1, 1'b1, 8'h2B); send(1, 1'b1, 8'h2B); end
    join
    wait_idle();
    chk("alt_grant_count", grants.size() == 4, grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      chk("alt_grant_seq", grants[k] == (k % 2), grants[k], k % 2);
    chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
